force_mem_readout: RTL and testbench

- Reader side of the on-board-test force recording memory: after a run, walks force-memory entries 0..N-1 and streams them to the host/debug path.
- Each 96-bit entry is {Force_Z, Force_Y, Force_X}. It is emitted as three 32-bit beats (X, then Y, then Z) on a valid/ready stream.
- Sits in the board-test top beside the force memory. While busy is high, the top muxes mem_address/mem_rden from this block onto the memory port.

---
 rtl/force_mem_readout_pkg.sv | 20 ++
 rtl/force_readout_fifo.sv | 77 +++++++
 rtl/force_mem_readout.sv | 221 ++++++++++++++++++++++
 tb/tb_force_mem_readout.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/force_mem_readout_pkg.sv
// Shared definitions for the force-memory readout block: controller state
// encoding, beat width and the component order within a 96-bit entry.
package force_mem_readout_pkg;

    localparam int COMP_WIDTH = 32;
    localparam int NUM_COMP   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Beat index of each force component inside one memory entry.
    localparam logic [1:0] FX = 2'd0;
    localparam logic [1:0] FY = 2'd1;
    localparam logic [1:0] FZ = 2'd2;

endpackage

// File: rtl/force_readout_fifo.sv
// Small synchronous FIFO that buffers force-memory words between the memory
// read pipe and the beat serialiser. The head entry is shown combinationally
// on rdata_o. Pushing into a full FIFO or popping an empty one is flagged by
// an immediate assertion.
module force_readout_fifo #(
    parameter int DATA_WIDTH = 96,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  full_o
);
    import force_mem_readout_pkg::*;

    logic [DATA_WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next pointer and occupancy values; push and pop together leave the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_i) store_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = store_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // Overflow and underflow must never happen; the read credit rule prevents them.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_o)) else $error("force_readout_fifo: push into full fifo");
            assert (!(pop_i && empty_o)) else $error("force_readout_fifo: pop from empty fifo");
        end
    end

endmodule

// File: rtl/force_mem_readout.sv
// Reader for the on-board-test force recording memory. Walks entries
// 0..N-1, buffers the read words and streams each one as three beats
// (X, Y, Z) on a valid/ready interface.
// Optional build macro FORCE_READOUT_CHECKSUM_EN appends one beat carrying
// the 32-bit wrapping sum of all data beats; out_last moves onto that beat.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; count latched (clamped to DEPTH) on start
// ST_READ  | issuing memory reads while buffer credit is available
// ST_DRAIN | all reads issued; waiting for the final beat to be accepted
// ST_DONE  | one-cycle done pulse, busy already low, back to idle
module force_mem_readout #(
    parameter int DATA_WIDTH = 96,
    parameter int COMP_WIDTH = 32,
    parameter int DEPTH      = 10000,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [COMP_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    import force_mem_readout_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W  = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
    logic [ADDR_WIDTH-1:0]   out_idx_q, out_idx_d;
    logic [1:0]              beat_q, beat_d;
    logic [RD_LATENCY-1:0]   pipe_q, pipe_d;

    logic [ADDR_WIDTH-1:0]   clamped;
    logic [IF_W-1:0]         inflight;
    logic                    credit_ok;
    logic                    issue;
    logic                    fifo_push, fifo_pop;
    logic [DATA_WIDTH-1:0]   fifo_rdata;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty, fifo_full;
    logic [COMP_WIDTH-1:0]   head_beat;
    logic                    data_valid, data_acc, final_acc;

    assign clamped = (num_words > DEPTH_A) ? DEPTH_A : num_words;

    // Reads still in the memory pipeline count against buffer space.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + IF_W'(pipe_q[i]);
        end
    end

    assign credit_ok = !fifo_full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

    // An issue bit leaving the pipe marks the cycle its read data is on mem_q.
    assign pipe_d    = (pipe_q << 1) | RD_LATENCY'(issue);
    assign fifo_push = pipe_q[RD_LATENCY-1];

    force_readout_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (mem_q),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Select the current component of the head entry.
    always_comb begin
        head_beat = fifo_rdata[COMP_WIDTH-1:0];
        case (beat_q)
            FY:      head_beat = fifo_rdata[2*COMP_WIDTH-1:COMP_WIDTH];
            FZ:      head_beat = fifo_rdata[3*COMP_WIDTH-1:2*COMP_WIDTH];
            default: head_beat = fifo_rdata[COMP_WIDTH-1:0];
        endcase
    end

    assign data_valid = !fifo_empty;
    assign data_acc   = data_valid && out_ready;
    assign fifo_pop   = data_acc && (beat_q == FZ);

`ifdef FORCE_READOUT_CHECKSUM_EN
    logic [COMP_WIDTH-1:0] csum_q, csum_d;
    logic                  csum_active;

    // The checksum beat follows once every data entry has been popped.
    assign csum_active = (state_q == ST_DRAIN) && fifo_empty && (out_idx_q == n_q);
    assign out_valid   = data_valid || csum_active;
    assign out_data    = csum_active ? csum_q : (data_valid ? head_beat : '0);
    assign out_last    = csum_active;
    assign final_acc   = csum_active && out_ready;

    // Running sum of accepted data beats, cleared on an accepted start.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && start) csum_d = '0;
        else if (data_acc)                 csum_d = csum_q + head_beat;
    end

    // Checksum register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`else
    logic is_last_entry;

    assign is_last_entry = (out_idx_q == n_q - 1'b1);
    assign out_valid     = data_valid;
    assign out_data      = data_valid ? head_beat : '0;
    assign out_last      = data_valid && (beat_q == FZ) && is_last_entry;
    assign final_acc     = data_acc && out_last;
`endif

    // Controller next state, read issue and beat/entry counters.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        rd_addr_d   = rd_addr_q;
        addr_hold_d = addr_hold_q;
        beat_d      = beat_q;
        out_idx_d   = out_idx_q;
        issue       = 1'b0;

        if (data_acc) begin
            if (beat_q == FZ) begin
                beat_d    = FX;
                out_idx_d = out_idx_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d       = clamped;
                    rd_addr_d = '0;
                    out_idx_d = '0;
                    beat_d    = FX;
                    if (clamped == '0) begin
`ifdef FORCE_READOUT_CHECKSUM_EN
                        state_d = ST_DRAIN;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    addr_hold_d = rd_addr_q;
                    rd_addr_d   = rd_addr_q + 1'b1;
                    if (rd_addr_q == n_q - 1'b1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_acc) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            rd_addr_q   <= '0;
            addr_hold_q <= '0;
            out_idx_q   <= '0;
            beat_q      <= FX;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            rd_addr_q   <= rd_addr_d;
            addr_hold_q <= addr_hold_d;
            out_idx_q   <= out_idx_d;
            beat_q      <= beat_d;
            pipe_q      <= pipe_d;
        end
    end

    assign mem_rden    = issue;
    assign mem_address = issue ? rd_addr_q : addr_hold_q;
    assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_force_mem_readout.sv
// Directed bench for force_mem_readout with a two-cycle-latency memory model.
module tb_force_mem_readout;

    localparam int AW = 14;
`ifdef FORCE_READOUT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] num_words;
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic [95:0]   mem_q;
    logic [31:0]   out_data;
    logic          out_valid, out_ready, out_last;

    int n_compared   = 0;
    int n_mismatched = 0;
    bit special_pat  = 1'b0;

    logic [AW-1:0] mem_a1;
    logic [95:0]   mem_q_r;

    force_mem_readout dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_words   (num_words),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    // Expected value of data beat k (entry k/3, component k%3).
    function automatic logic [31:0] comp(input int k);
        int e;
        e = k / 3;
        if (special_pat) begin
            case (k % 3)
                0:       return 32'd1;
                1:       return 32'd2;
                default: return 32'hFFFF_FFFF;
            endcase
        end
        case (k % 3)
            0:       return 32'(e + 1);
            1:       return 32'(e + 32'h100);
            default: return 32'(e + 32'h10000);
        endcase
    endfunction

    function automatic logic [95:0] mem_word(input int a);
        return {comp(3 * a + 2), comp(3 * a + 1), comp(3 * a)};
    endfunction

    // Memory: address register then output register.
    always @(posedge clk) begin
        if (mem_rden) mem_a1 <= mem_address;
        mem_q_r <= mem_word(int'(mem_a1));
    end
    assign mem_q = mem_q_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_readout(input int req, input int n_exp, input bit toggle, input int max_cyc);
        int          total, beats, issued, popped, last_acc;
        bit          got_done;
        logic [31:0] sum, exp_d;
        total    = 3 * n_exp + CS;
        beats    = 0;
        issued   = 0;
        popped   = 0;
        last_acc = -1;
        got_done = 1'b0;
        sum      = '0;
        start     = 1'b1;
        num_words = AW'(req);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < max_cyc && !got_done; cyc++) begin
            out_ready = toggle ? (cyc % 3 == 2) : 1'b1;
            if (mem_rden) begin
                chk("rden_credit", 64'(issued - popped < 4), 64'd1);
                chk("rd_addr", 64'(mem_address), 64'(issued));
                issued++;
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_beats", 64'(beats), 64'(total));
                chk("done_issued", 64'(issued), 64'(n_exp));
                chk("done_timing", 64'(cyc), 64'(last_acc + 1));
                chk("busy_at_done", 64'(busy), 64'd0);
            end else begin
                chk("busy_run", 64'(busy), 64'd1);
                if (out_valid) begin
                    exp_d = (beats < 3 * n_exp) ? comp(beats) : sum;
                    chk("beat_data", 64'(out_data), 64'(exp_d));
                    chk("beat_last", 64'(out_last), 64'(beats == total - 1));
                    if (out_ready) begin
                        if (beats < 3 * n_exp) sum = sum + exp_d;
                        beats++;
                        if (beats % 3 == 0 && beats <= 3 * n_exp) popped++;
                        last_acc = cyc;
                    end
                end
                @(negedge clk);
            end
        end
        if (!got_done) chk("done_timeout", 64'(got_done), 64'd1);
    endtask

    // Optionally pulse start during the DONE cycle; it must be ignored.
    task automatic after_done(input bit poke);
        if (poke) begin
            start     = 1'b1;
            num_words = AW'(1);
        end
        @(negedge clk);
        start = 1'b0;
        chk("post_done", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_rden", 64'(mem_rden), 64'd0);
        @(negedge clk);
        chk("post_busy2", 64'(busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        num_words = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rden", 64'(mem_rden), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic readout, start in the DONE cycle ignored afterwards.
        run_readout(3, 3, 1'b0, 100);
        after_done(1'b1);

        // Zero-length readout.
        run_readout(0, 0, 1'b0, 20);
        after_done(1'b0);

        // Back-pressure: ready one cycle in three.
        run_readout(8, 8, 1'b1, 300);
        after_done(1'b0);

        // Single entry.
        run_readout(1, 1, 1'b0, 50);
        after_done(1'b0);

        // Reset while reading entry 5, then a fresh short readout.
        out_ready = 1'b1;
        start     = 1'b1;
        num_words = AW'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !(mem_rden && mem_address == AW'(5)); i++) @(negedge clk);
        chk("mid_reached", 64'(mem_rden && mem_address == AW'(5)), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_rden", 64'(mem_rden), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_done", 64'(done), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_idle_done", 64'(done), 64'd0);
        run_readout(2, 2, 1'b0, 50);
        after_done(1'b0);

        // Oversized request clamps to the full memory depth.
        run_readout(16383, 10000, 1'b0, 31000);
        after_done(1'b0);

`ifdef FORCE_READOUT_CHECKSUM_EN
        // Checksum wraps: 1 + 2 + 0xFFFFFFFF = 2.
        special_pat = 1'b1;
        run_readout(1, 1, 1'b0, 50);
        after_done(1'b0);
        special_pat = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
